spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_GAP, default 4: minimum clk cycles nCS is held high between frames; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  frame request; accepted only in a cycle where ready=1.
REQ-006 rw  input  1  frame bit 15 (1 = write); captured on accept.
REQ-007 addr  input  7  frame bits 14:8; captured on accept.
REQ-008 wdata  input  8  frame bits 7:0; captured on accept.
REQ-009 ready  output  1  high when IDLE and able to accept start.
REQ-010 done  output  1  one-cycle pulse at end of frame.
REQ-011 rdata  output  8  last 8 bits sampled from CIPO in the most recent completed frame.
REQ-012 nCS  output  1  chip select, active low, registered.
REQ-013 SCLK  output  1  SPI clock, mode 0 (idle low), registered.
REQ-014 COPI  output  1  serial data out, MSB first, registered.
REQ-015 CIPO  input  1  serial data in; sampled directly, no synchronizer.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-017 IDLE: ready=1, nCS=1, SCLK=0; start=1 -> latch {rw,addr,wdata} into a 16-bit tx shift register, go to SETUP.
REQ-018 SETUP: nCS=0 from the cycle after accept, COPI=frame[15], SCLK=0; lasts CLK_DIV cycles, then SHIFT.
REQ-019 SHIFT: SCLK toggles every CLK_DIV cycles for exactly 32 half-periods (16 rising, 16 falling edges), starting with a rising edge.
REQ-020 On each SCLK rising edge, CIPO SHALL be shifted into an rx shift register, LSB in; a 5-bit bit counter SHALL increment.
REQ-021 On each SCLK falling edge except the 16th, COPI SHALL advance to the next lower frame bit; COPI is stable across every rising edge.
REQ-022 After the 16th falling edge -> HOLD: nCS=0, SCLK=0 for CLK_DIV cycles.
REQ-023 HOLD end: nCS=1, done=1 for that single cycle, rdata <= rx[7:0] in the same cycle, go to GAP.
REQ-024 GAP: ready=0, nCS=1 for CS_GAP cycles, then IDLE.
REQ-025 nCS low duration per frame SHALL be exactly 34*CLK_DIV cycles; accept-to-done latency 34*CLK_DIV+1 cycles.
REQ-026 start while ready=0 SHALL be ignored and not queued; rw/addr/wdata changes after accept SHALL not affect the frame in flight.
REQ-027 start held high continuously SHALL produce back-to-back frames with nCS high exactly CS_GAP+1 cycles between them.
REQ-028 The divider counter SHALL reset to 0 on every state transition and on every SCLK toggle; no wrap-around glitch on SCLK.
REQ-029 rw=0 frames SHALL be transmitted identically; only rdata interpretation differs.

Reset
REQ-030 While rst_n=0: state=IDLE, nCS=1, SCLK=0, COPI=0, done=0, ready=1, rdata=8'h00, shift/bit/divider counters cleared.
REQ-031 Reset asserted mid-frame SHALL force nCS high and SCLK low asynchronously; no done pulse; rdata keeps reset value 0.
REQ-032 First accept after reset release SHALL be honoured in the first clock edge with rst_n=1.

Verification
REQ-033 CLK_DIV=4: start, rw=1, addr=0x04, wdata=0x80 -> COPI at 16 SCLK rising edges = 0x8480, nCS low 136 cycles, one done pulse.
REQ-034 Loop to a receiver model: write 0x00<-0xFF then 0x03<-0x5A -> model registers 0x00=0xFF, 0x03=0x5A.
REQ-035 CIPO driven 0xA5 during bits 7:0 -> rdata=0xA5 in the done cycle; upper 8 sampled bits discarded.
REQ-036 start pulsed at cycles 5, 20, 60 of a frame -> ignored; exactly one frame, one done.
REQ-037 start held high, CS_GAP=4 -> two frames, nCS high 5 cycles between; SCLK low throughout the gap.
REQ-038 rst_n low at 8th rising SCLK edge -> nCS=1, SCLK=0 immediately; done never pulses; ready=1 after release.

Source files
------------

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 master that shifts one 16-bit {rw,addr,wdata} frame per request
// A single divider counter paces SETUP, every SCLK half-period, HOLD and the inter-frame GAP.
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  input  logic       CIPO
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        done_q, done_d;
  logic        div_tick;

  assign div_tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    rdata_d = rdata_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = 8'd0;
        if (start) begin
          tx_d    = {rw, addr, wdata};
          copi_d  = rw;
          ncs_d   = 1'b0;
          bit_d   = 5'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_tick) begin
          div_d   = 8'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // SCLK is low for the first half-period, so the 32nd toggle is the 16th falling edge.
        if (div_tick) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d  = {rx_q[6:0], CIPO};
            bit_d = bit_q + 5'd1;
          end else if (bit_q == 5'd16) begin
            state_d = S_HOLD;
          end else begin
            tx_d   = {tx_q[14:0], 1'b0};
            copi_d = tx_q[14];
          end
        end
      end
      S_HOLD: begin
        if (div_tick) begin
          div_d   = 8'd0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          rdata_d = rx_q;
          copi_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        div_d   = 8'd0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      tx_q    <= 16'd0;
      rx_q    <= 8'd0;
      bit_q   <= 5'd0;
      rdata_q <= 8'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      rdata_q <= rdata_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;
  assign nCS   = ncs_q;
  assign SCLK  = sclk_q;
  assign COPI  = copi_q;

endmodule
